// File: rtl/operand_fetch_seq_pkg.sv
// Shared types and default sizes for the operand fetch sequencer.
package operand_fetch_seq_pkg;

    localparam int unsigned DEF_SIZE    = 16;
    localparam int unsigned DEF_REGBITS = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        CAPT     = 3'd2,
        ISSUE    = 3'd3,
        WAIT_RES = 3'd4,
        WB       = 3'd5
    } seqState_t;

endpackage

// File: rtl/opfetch_instr_latch.sv
// Capture register for one decoded instruction; load on accept, cleared by reset.
module opfetch_instr_latch
    import operand_fetch_seq_pkg::*;
#(
    parameter int unsigned SIZE    = DEF_SIZE,
    parameter int unsigned REGBITS = DEF_REGBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [REGBITS-1:0] inSrc,
    input  logic [REGBITS-1:0] inDst,
    input  logic               inWb,
    input  logic               inUseImm,
    input  logic [SIZE-1:0]    inImm,
    output logic [REGBITS-1:0] src,
    output logic [REGBITS-1:0] dst,
    output logic               wb,
    output logic               useImm,
    output logic [SIZE-1:0]    imm
);

    always_ff @(posedge clk) begin
        if (reset) begin
            src    <= '0;
            dst    <= '0;
            wb     <= 1'b0;
            useImm <= 1'b0;
            imm    <= '0;
        end else if (load) begin
            src    <= inSrc;
            dst    <= inDst;
            wb     <= inWb;
            useImm <= inUseImm;
            imm    <= inImm;
        end
    end

endmodule

// File: rtl/operand_fetch_seq.sv
// Register-file operand fetch / ALU issue / writeback sequencer.
// Optional build macro OPFETCH_R0_ZERO_EN hardwires register 0 to zero.
module operand_fetch_seq
    import operand_fetch_seq_pkg::*;
#(
    parameter int unsigned SIZE    = DEF_SIZE,
    parameter int unsigned REGBITS = DEF_REGBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inValid,
    output logic               inReady,
    input  logic [REGBITS-1:0] inSrc,
    input  logic [REGBITS-1:0] inDst,
    input  logic               inWb,
    input  logic               inUseImm,
    input  logic [SIZE-1:0]    inImm,
    output logic [REGBITS-1:0] rfSrcAddr,
    output logic [REGBITS-1:0] rfDstAddr,
    input  logic [SIZE-1:0]    rfReadData1,
    input  logic [SIZE-1:0]    rfReadData2,
    output logic               rfWriteEn,
    output logic [SIZE-1:0]    rfWriteData,
    output logic               opValid,
    input  logic               opReady,
    output logic [SIZE-1:0]    opA,
    output logic [SIZE-1:0]    opB,
    input  logic               resValid,
    output logic               resReady,
    input  logic [SIZE-1:0]    resData,
    output logic               busy
);

    seqState_t          state;
    logic               accept;
    logic [REGBITS-1:0] src;
    logic [REGBITS-1:0] dst;
    logic               wb;
    logic               useImm;
    logic [SIZE-1:0]    imm;
    logic [SIZE-1:0]    capA;
    logic [SIZE-1:0]    capB;
    logic               wbAllowed;

    assign accept = (state == IDLE) && inValid;

    opfetch_instr_latch #(
        .SIZE    (SIZE),
        .REGBITS (REGBITS)
    ) u_latch (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .inSrc    (inSrc),
        .inDst    (inDst),
        .inWb     (inWb),
        .inUseImm (inUseImm),
        .inImm    (inImm),
        .src      (src),
        .dst      (dst),
        .wb       (wb),
        .useImm   (useImm),
        .imm      (imm)
    );

    // Operand selection at capture, with optional r0-as-zero masking.
`ifdef OPFETCH_R0_ZERO_EN
    assign capA      = (dst == '0) ? '0 : rfReadData1;
    assign capB      = useImm ? imm : ((src == '0) ? '0 : rfReadData2);
    assign wbAllowed = (dst != '0);
`else
    assign capA      = rfReadData1;
    assign capB      = useImm ? imm : rfReadData2;
    assign wbAllowed = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            opA         <= '0;
            opB         <= '0;
            rfWriteData <= '0;
        end else begin
            case (state)
                IDLE:     if (inValid) state <= ADDR;
                ADDR:     state <= CAPT;
                CAPT: begin
                    opA   <= capA;
                    opB   <= capB;
                    state <= ISSUE;
                end
                ISSUE:    if (opReady) state <= WAIT_RES;
                WAIT_RES: begin
                    if (resValid) begin
                        rfWriteData <= resData;
                        state       <= wb ? WB : IDLE;
                    end
                end
                WB:       state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // Addresses come straight from the latch so they only move on accept.
    assign rfSrcAddr = src;
    assign rfDstAddr = dst;

    assign inReady   = (state == IDLE);
    assign opValid   = (state == ISSUE);
    assign resReady  = (state == WAIT_RES);
    assign busy      = (state != IDLE);
    assign rfWriteEn = (state == WB) && wbAllowed;

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Directed bench for operand_fetch_seq with a behavioural 16x16 register file.
module tb_operand_fetch_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [3:0]  inSrc = '0;
    logic [3:0]  inDst = '0;
    logic        inWb = 1'b0;
    logic        inUseImm = 1'b0;
    logic [15:0] inImm = '0;
    logic [3:0]  rfSrcAddr;
    logic [3:0]  rfDstAddr;
    logic [15:0] rfReadData1;
    logic [15:0] rfReadData2;
    logic        rfWriteEn;
    logic [15:0] rfWriteData;
    logic        opValid;
    logic        opReady = 1'b0;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        resValid = 1'b0;
    logic        resReady;
    logic [15:0] resData = '0;
    logic        busy;

    logic        plEn = 1'b0;
    logic [3:0]  plAddr = '0;
    logic [15:0] plData = '0;

    logic [15:0] regs [16];
    logic [15:0] shadow [16];
    logic [19:0] wrLog [$];
    logic [19:0] wrExpQ [$];
    logic [31:0] opQ [$];

    int nErr = 0;
    int nChecks = 0;

    operand_fetch_seq dut (
        .clk         (clk),
        .reset       (reset),
        .inValid     (inValid),
        .inReady     (inReady),
        .inSrc       (inSrc),
        .inDst       (inDst),
        .inWb        (inWb),
        .inUseImm    (inUseImm),
        .inImm       (inImm),
        .rfSrcAddr   (rfSrcAddr),
        .rfDstAddr   (rfDstAddr),
        .rfReadData1 (rfReadData1),
        .rfReadData2 (rfReadData2),
        .rfWriteEn   (rfWriteEn),
        .rfWriteData (rfWriteData),
        .opValid     (opValid),
        .opReady     (opReady),
        .opA         (opA),
        .opB         (opB),
        .resValid    (resValid),
        .resReady    (resReady),
        .resData     (resData),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Register file: registered reads, write commits at the clock edge.
    always @(posedge clk) begin
        rfReadData1 <= regs[rfDstAddr];
        rfReadData2 <= regs[rfSrcAddr];
        if (plEn) regs[plAddr] <= plData;
        if (rfWriteEn) begin
            regs[rfDstAddr] <= rfWriteData;
            wrLog.push_back({rfDstAddr, rfWriteData});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        plEn = 1'b1; plAddr = a; plData = d;
        tick();
        plEn = 1'b0;
        shadow[a] = d;
    endtask

    task automatic checkWrites(input string tag);
        logic [19:0] got, want;
        check({tag, "_wrcount"}, 32'(wrLog.size()), 32'(wrExpQ.size()));
        while (wrLog.size() > 0 && wrExpQ.size() > 0) begin
            got  = wrLog.pop_front();
            want = wrExpQ.pop_front();
            check({tag, "_wr"}, 32'(got), 32'(want));
        end
        wrLog.delete();
        wrExpQ.delete();
    endtask

    // One full instruction from accept to return to IDLE; expectations from shadow model.
    task automatic runInstr(input string tag, input logic [3:0] s, input logic [3:0] d,
                            input logic w, input logic u, input logic [15:0] imm,
                            input logic [15:0] res, input int stall);
        logic [15:0] ea, eb;
        logic [31:0] ops;
        logic        expWe;
        ea = shadow[d];
        eb = u ? imm : shadow[s];
        expWe = 1'b1;
`ifdef OPFETCH_R0_ZERO_EN
        if (d == 4'd0) begin ea = '0; expWe = 1'b0; end
        if (!u && s == 4'd0) eb = '0;
`endif
        opQ.push_back({ea, eb});
        if (w && expWe) begin
            wrExpQ.push_back({d, res});
            shadow[d] = res;
        end

        check({tag, "_inReady_idle"}, 32'(inReady), 32'd1);
        inValid = 1'b1; inSrc = s; inDst = d; inWb = w; inUseImm = u; inImm = imm;
        tick();
        inValid = 1'b0; inSrc = ~s; inDst = ~d; inWb = ~w; inUseImm = ~u; inImm = ~imm;
        check({tag, "_busy_addr"}, 32'(busy), 32'd1);
        check({tag, "_srcAddr"}, 32'(rfSrcAddr), 32'(s));
        check({tag, "_dstAddr_addr"}, 32'(rfDstAddr), 32'(d));
        tick();
        check({tag, "_opValid_capt"}, 32'(opValid), 32'd0);
        check({tag, "_dstAddr_capt"}, 32'(rfDstAddr), 32'(d));
        tick();
        check({tag, "_opValid_c3"}, 32'(opValid), 32'd1);
        ops = opQ.pop_front();
        check({tag, "_opA"}, 32'(opA), 32'(ops[31:16]));
        check({tag, "_opB"}, 32'(opB), 32'(ops[15:0]));
        for (int i = 0; i < stall; i++) begin
            inValid  = (i == 1);
            resValid = (i == 2);
            resData  = 16'hDEAD;
            tick();
            inValid  = 1'b0;
            resValid = 1'b0;
            check({tag, "_stall_opValid"}, 32'(opValid), 32'd1);
            check({tag, "_stall_opA"}, 32'(opA), 32'(ops[31:16]));
            check({tag, "_stall_opB"}, 32'(opB), 32'(ops[15:0]));
            check({tag, "_stall_inReady"}, 32'(inReady), 32'd0);
        end
        check({tag, "_dstAddr_issue"}, 32'(rfDstAddr), 32'(d));
        opReady = 1'b1;
        tick();
        opReady = 1'b0;
        check({tag, "_resReady"}, 32'(resReady), 32'd1);
        check({tag, "_opValid_wait"}, 32'(opValid), 32'd0);
        check({tag, "_dstAddr_wait"}, 32'(rfDstAddr), 32'(d));
        resValid = 1'b1; resData = res;
        tick();
        resValid = 1'b0; resData = 16'h0BAD;
        if (w) begin
            check({tag, "_wrEn_wb"}, 32'(rfWriteEn), 32'(expWe));
            check({tag, "_dstAddr_wb"}, 32'(rfDstAddr), 32'(d));
            check({tag, "_wrData_wb"}, 32'(rfWriteData), 32'(res));
            check({tag, "_busy_wb"}, 32'(busy), 32'd1);
            tick();
        end
        check({tag, "_wrEn_idle"}, 32'(rfWriteEn), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_inReady_done"}, 32'(inReady), 32'd1);
        checkWrites(tag);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_inReady", 32'(inReady), 32'd1);
        check("rst_opValid", 32'(opValid), 32'd0);
        check("rst_resReady", 32'(resReady), 32'd0);
        check("rst_wrEn", 32'(rfWriteEn), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_srcAddr", 32'(rfSrcAddr), 32'd0);
        check("rst_dstAddr", 32'(rfDstAddr), 32'd0);
        check("rst_opA", 32'(opA), 32'd0);

        for (int i = 0; i < 16; i++) preload(4'(i), 16'h0100 + 16'(i));
        preload(4'd3, 16'h0010);
        preload(4'd5, 16'h0022);
        preload(4'd0, 16'h0AAA);

        runInstr("regreg", 4'd5, 4'd3, 1'b1, 1'b0, 16'h0000, 16'h0032, 0);
        runInstr("imm", 4'd5, 4'd3, 1'b0, 1'b1, 16'hBEEF, 16'h7777, 0);
        runInstr("stall", 4'd9, 4'd6, 1'b1, 1'b0, 16'h0000, 16'h4321, 4);
        runInstr("raw1", 4'd2, 4'd7, 1'b1, 1'b0, 16'h0000, 16'h1234, 0);
        runInstr("raw2", 4'd7, 4'd8, 1'b1, 1'b0, 16'h0000, 16'h2222, 0);

        // Abandon an instruction with reset while waiting for the result.
        inValid = 1'b1; inSrc = 4'd1; inDst = 4'd2; inWb = 1'b1; inUseImm = 1'b0;
        tick();
        inValid = 1'b0;
        tick();
        tick();
        opReady = 1'b1;
        tick();
        opReady = 1'b0;
        check("mid_resReady", 32'(resReady), 32'd1);
        reset = 1'b1; resValid = 1'b1; resData = 16'hDEAD;
        tick();
        reset = 1'b0; resValid = 1'b0;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_inReady", 32'(inReady), 32'd1);
        check("mid_resReady_after", 32'(resReady), 32'd0);
        check("mid_dstAddr", 32'(rfDstAddr), 32'd0);
        check("mid_opA", 32'(opA), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_wrEn", 32'(rfWriteEn), 32'd0);
        end
        checkWrites("mid");
        runInstr("postrst", 4'd8, 4'd4, 1'b1, 1'b0, 16'h0000, 16'h00F0, 0);

        runInstr("r0", 4'd0, 4'd0, 1'b1, 1'b0, 16'h0000, 16'h5555, 0);
        runInstr("r0read", 4'd0, 4'd1, 1'b0, 1'b0, 16'h0000, 16'h0000, 0);

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule
